// File: rtl/id_stage_hz.sv
// MIPS instruction-decode stage: register file with write-through bypass,
// load-use bubble insertion, stall/flush control and a registered ID/EX bundle.

module id_rd_port #(
   parameter int DATA_W    = 32,
   parameter int REG_COUNT = 32
) (
   input  logic [REG_COUNT-1:0][DATA_W-1:0] rf,
   input  logic [4:0]                       addr,
   input  logic                             wr_en,
   input  logic [4:0]                       wr_addr,
   input  logic [DATA_W-1:0]                wr_data,
   output logic [DATA_W-1:0]                data
);
   // Mux over implemented registers only; r0 and unimplemented addresses fall through to 0.
   always_comb begin
      data = '0;
      if (wr_en && wr_addr == addr) begin
         data = wr_data;
      end else begin
         for (int i = 1; i < REG_COUNT; i++) begin
            if (addr == 5'(i)) data = rf[i];
         end
      end
   end
endmodule

module id_stage_hz #(
   parameter int DATA_W    = 32,
   parameter int REG_COUNT = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       instruction,
   input  logic              in_valid,
   input  logic              stall,
   input  logic              flush,
   input  logic              register_write,
   input  logic [4:0]        write_addr,
   input  logic [DATA_W-1:0] write_result,
   output logic [DATA_W-1:0] rs,
   output logic [DATA_W-1:0] rt,
   output logic [4:0]        rt_addr,
   output logic [4:0]        rd_addr,
   output logic [4:0]        shamt,
   output logic [DATA_W-1:0] extended_imm,
   output logic              out_valid,
   output logic              mem_read,
   output logic              load_use_stall
);
   localparam int NUM_RD = 2;

   logic [5:0]  op;
   logic [4:0]  f_rs, f_rt, f_rd, f_shamt;
   logic [15:0] imm;
   logic        unused_funct;

   assign op           = instruction[31:26];
   assign f_rs         = instruction[25:21];
   assign f_rt         = instruction[20:16];
   assign f_rd         = instruction[15:11];
   assign f_shamt      = instruction[10:6];
   assign imm          = instruction[15:0];
   assign unused_funct = ^instruction[5:0];

   logic [REG_COUNT-1:0][DATA_W-1:0] rf_q;
   logic [4:0]                       rs_addr_q;
   logic                             wr_en;

   assign wr_en = register_write && (write_addr != 5'd0) && (32'(write_addr) < REG_COUNT);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rf_q <= '0;
      end else begin
         for (int i = 1; i < REG_COUNT; i++) begin
            if (wr_en && write_addr == 5'(i)) rf_q[i] <= write_result;
         end
      end
   end

   // While stalled, operands are re-read from the held addresses so writebacks land.
   logic [NUM_RD-1:0][4:0]        rd_sel;
   logic [NUM_RD-1:0][DATA_W-1:0] rd_data;

   assign rd_sel[0] = stall ? rs_addr_q : f_rs;
   assign rd_sel[1] = stall ? rt_addr   : f_rt;

   for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
      id_rd_port #(.DATA_W(DATA_W), .REG_COUNT(REG_COUNT)) u_rd (
         .rf      (rf_q),
         .addr    (rd_sel[g]),
         .wr_en   (wr_en),
         .wr_addr (write_addr),
         .wr_data (write_result),
         .data    (rd_data[g])
      );
   end

   logic [DATA_W-1:0] imm_ext;
   always_comb begin
      imm_ext = DATA_W'($signed(imm));
      case (op)
         6'h0c, 6'h0d, 6'h0e: imm_ext = DATA_W'(imm);
         6'h0f:               imm_ext = DATA_W'({imm, 16'h0000});
         default:             ;
      endcase
   end

   // rt only matters as a source for R-type, branches and store data.
   logic rt_is_src, hazard;
   assign rt_is_src = (op == 6'h00) || (op == 6'h04) || (op == 6'h05) || (op == 6'h2b);
   assign hazard    = in_valid && mem_read && out_valid && (rt_addr != 5'd0) &&
                      ((f_rs == rt_addr) || (rt_is_src && f_rt == rt_addr));
   assign load_use_stall = hazard && !stall && !flush;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rs           <= '0;
         rt           <= '0;
         rs_addr_q    <= '0;
         rt_addr      <= '0;
         rd_addr      <= '0;
         shamt        <= '0;
         extended_imm <= '0;
         out_valid    <= 1'b0;
         mem_read     <= 1'b0;
      end else if (flush || load_use_stall) begin
         rs           <= '0;
         rt           <= '0;
         rs_addr_q    <= '0;
         rt_addr      <= '0;
         rd_addr      <= '0;
         shamt        <= '0;
         extended_imm <= '0;
         out_valid    <= 1'b0;
         mem_read     <= 1'b0;
      end else if (stall) begin
         rs <= rd_data[0];
         rt <= rd_data[1];
      end else begin
         rs           <= rd_data[0];
         rt           <= rd_data[1];
         rs_addr_q    <= f_rs;
         rt_addr      <= f_rt;
         rd_addr      <= f_rd;
         shamt        <= f_shamt;
         extended_imm <= imm_ext;
         out_valid    <= in_valid;
         mem_read     <= in_valid && (op == 6'h23);
      end
   end
endmodule

// File: tb/tb_id_stage_hz.sv
// Directed bench for id_stage_hz: default, 64-bit and 16-register instances share stimulus.

module tb_id_stage_hz;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] instruction = '0;
   logic        in_valid = 1'b0, stall = 1'b0, flush = 1'b0;
   logic        register_write = 1'b0;
   logic [4:0]  write_addr = '0;
   logic [31:0] write_result = '0;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   logic [31:0] rs, rt, ext;
   logic [4:0]  rt_a, rd_a, sh;
   logic        ov, mr, lus;
   id_stage_hz dut (
      .clk(clk), .reset(reset), .instruction(instruction), .in_valid(in_valid),
      .stall(stall), .flush(flush), .register_write(register_write),
      .write_addr(write_addr), .write_result(write_result),
      .rs(rs), .rt(rt), .rt_addr(rt_a), .rd_addr(rd_a), .shamt(sh),
      .extended_imm(ext), .out_valid(ov), .mem_read(mr), .load_use_stall(lus));

   logic [63:0] rs64, rt64, ext64;
   logic [4:0]  rt_a64, rd_a64, sh64;
   logic        ov64, mr64, lus64;
   id_stage_hz #(.DATA_W(64)) dut64 (
      .clk(clk), .reset(reset), .instruction(instruction), .in_valid(in_valid),
      .stall(stall), .flush(flush), .register_write(register_write),
      .write_addr(write_addr), .write_result({32'h0, write_result}),
      .rs(rs64), .rt(rt64), .rt_addr(rt_a64), .rd_addr(rd_a64), .shamt(sh64),
      .extended_imm(ext64), .out_valid(ov64), .mem_read(mr64), .load_use_stall(lus64));

   logic [31:0] rs16, rt16, ext16;
   logic [4:0]  rt_a16, rd_a16, sh16;
   logic        ov16, mr16, lus16;
   id_stage_hz #(.REG_COUNT(16)) dut16 (
      .clk(clk), .reset(reset), .instruction(instruction), .in_valid(in_valid),
      .stall(stall), .flush(flush), .register_write(register_write),
      .write_addr(write_addr), .write_result(write_result),
      .rs(rs16), .rt(rt16), .rt_addr(rt_a16), .rd_addr(rd_a16), .shamt(sh16),
      .extended_imm(ext16), .out_valid(ov16), .mem_read(mr16), .load_use_stall(lus16));

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] rtype(input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
      return {6'h00, s, t, d, 5'd0, 6'h20};
   endfunction

   function automatic logic [31:0] itype(input logic [5:0] o, input logic [4:0] s, input logic [4:0] t,
                                         input logic [15:0] i);
      return {o, s, t, i};
   endfunction

   task automatic drive(input logic [31:0] ins, input logic v, input logic we,
                        input logic [4:0] wa, input logic [31:0] wd);
      instruction = ins; in_valid = v; register_write = we; write_addr = wa; write_result = wd;
   endtask

   initial begin
      // reset state
      step(); step();
      chk("rst_ov", ov, 0); chk("rst_rs", rs, 0); chk("rst_ext", ext, 0);
      chk("rst_mr", mr, 0); chk("rst_lus", lus, 0);
      reset = 1'b0;

      // write r5, read it back, then async reset clears it
      drive(32'h0, 0, 1, 5'd5, 32'hDEADBEEF); step();
      drive(rtype(5, 0, 1), 1, 0, 0, 0); step();
      chk("r5_read", rs, 32'hDEADBEEF); chk("r5_ov", ov, 1);
      #2 reset = 1'b1; #1;
      chk("async_rst_ov", ov, 0); chk("async_rst_rs", rs, 0); chk("async_rst_rd", rd_a, 0);
      #1 reset = 1'b0;
      step();
      chk("r5_after_rst", rs, 0); chk("r5_after_rst_ov", ov, 1); chk("r5_after_rst_rd", rd_a, 1);

      // same-cycle bypass, r0 write ignored
      drive(rtype(3, 0, 1), 1, 1, 5'd3, 32'h1234); step();
      chk("bypass_rs", rs, 32'h1234); chk("bypass_rt", rt, 0);
      drive(rtype(0, 0, 2), 1, 1, 5'd0, 32'h55); step();
      chk("r0_write_rs", rs, 0); chk("r0_rd", rd_a, 2);

      // immediates
      drive(itype(6'h0d, 0, 1, 16'h8001), 1, 0, 0, 0); step();
      chk("ori_imm", ext, 32'h00008001);
      drive(itype(6'h08, 0, 1, 16'h8001), 1, 0, 0, 0); step();
      chk("addi_imm", ext, 32'hFFFF8001); chk("addi_imm64", ext64, 64'hFFFFFFFFFFFF8001);
      drive(itype(6'h0f, 0, 1, 16'h8001), 1, 0, 0, 0); step();
      chk("lui_imm", ext, 32'h80010000); chk("lui_imm64", ext64, 64'h0000000080010000);

      // load-use: one bubble, dependent add captured afterwards
      drive(itype(6'h23, 1, 2, 16'h0), 1, 0, 0, 0); step();
      chk("lw_mr", mr, 1); chk("lw_rt_addr", rt_a, 2);
      drive(rtype(2, 5, 4), 1, 0, 0, 0); #1;
      chk("lu_stall", lus, 1);
      step();
      chk("lu_bubble_ov", ov, 0); chk("lu_bubble_mr", mr, 0); chk("lu_bubble_rd", rd_a, 0);
      chk("lu_released", lus, 0);
      step();
      chk("lu_add_ov", ov, 1); chk("lu_add_rd", rd_a, 4);

      // no stall: lw to r0, and independent add
      drive(itype(6'h23, 1, 0, 16'h0), 1, 0, 0, 0); step();
      drive(rtype(0, 5, 4), 1, 0, 0, 0); #1;
      chk("lw_r0_nostall", lus, 0);
      drive(itype(6'h23, 1, 2, 16'h0), 1, 0, 0, 0); step();
      drive(rtype(3, 5, 4), 1, 0, 0, 0); #1;
      chk("indep_nostall", lus, 0);
      drive(itype(6'h2b, 1, 2, 16'h0), 1, 0, 0, 0); #1;
      chk("sw_data_stall", lus, 1);
      step();

      // stall refresh of rs from the held address
      drive(32'h0, 0, 1, 5'd7, 32'd1); step();
      drive(rtype(7, 0, 1), 1, 0, 0, 0); step();
      chk("pre_stall_rs", rs, 1);
      stall = 1'b1;
      drive(rtype(3, 3, 9), 1, 1, 5'd7, 32'd9); step();
      chk("stall_rd_hold", rd_a, 1); chk("stall_rs_refresh", rs, 9); chk("stall_ov_hold", ov, 1);
      drive(rtype(3, 3, 9), 1, 0, 0, 0); step();
      chk("stall2_rs", rs, 9); chk("stall2_rd", rd_a, 1);
      stall = 1'b0; step();
      chk("unstall_rd", rd_a, 9); chk("unstall_rs", rs, 32'h1234);

      // flush beats stall and hazard
      drive(itype(6'h23, 1, 2, 16'h0), 1, 0, 0, 0); step();
      drive(rtype(2, 5, 4), 1, 0, 0, 0); stall = 1'b1; flush = 1'b1; #1;
      chk("flush_lus_masked", lus, 0);
      step();
      chk("flush_ov", ov, 0); chk("flush_mr", mr, 0); chk("flush_rd", rd_a, 0);
      stall = 1'b0; flush = 1'b0;

      // REG_COUNT=16 ignores r20
      drive(rtype(20, 20, 1), 1, 1, 5'd20, 32'hABCD); step();
      chk("rc16_bypass_rs", rs16, 0); chk("rc32_bypass_rs", rs, 32'hABCD);
      drive(rtype(20, 20, 1), 1, 0, 0, 0); step();
      chk("rc16_read_rs", rs16, 0); chk("rc32_read_rt", rt, 32'hABCD);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/id_stage_hz.md
# id_stage_hz

Parametrised instruction-decode pipeline stage for the MIPS pipelined CPU: register file with asynchronous reset, same-cycle write-through bypass, stall/flush control, load-use hazard detection with automatic bubble insertion, and a registered ID/EX output bundle with a valid bit. It sits between the IF/ID register and the execute stage, and receives writeback traffic from the WB stage.

## Interface
- DATA_W, 32: register and datapath width (≥32); immediates extend to DATA_W.
- REG_COUNT, 32: implemented registers (2..32); addresses ≥ REG_COUNT read 0, writes ignored.

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; clears register file and all outputs.
- instruction  in  32  instruction from IF/ID.
- in_valid  in  1  instruction is real (0 = bubble).
- stall  in  1  downstream hold request.
- flush  in  1  squash (branch/jump redirect).
- register_write  in  1  writeback enable.
- write_addr  in  5  writeback register.
- write_result  in  DATA_W  writeback data.
- rs, rt  out  DATA_W  registered operand values.
- rt_addr, rd_addr, shamt  out  5  registered instruction fields.
- extended_imm  out  DATA_W  registered extended immediate.
- out_valid  out  1  ID/EX content valid.
- mem_read  out  1  registered: stage holds a valid lw (op 0x23).
- load_use_stall  out  1  combinational: upstream must hold IF/ID this cycle.

## Operation
- Fields: op=[31:26], rs field=[25:21], rt field=[20:16], rd=[15:11], shamt=[10:6], imm=[15:0].
- Register 0 reads 0 always; writes to 0 ignored.
- Register write on posedge when register_write=1, write_addr≠0, write_addr<REG_COUNT.
- Bypass: a read whose address equals a same-cycle valid write address (≠0) returns write_result, not the stale array value.
- Immediate: op 0x0c/0x0d/0x0e zero-extend; op 0x0f (lui) = imm<<16, zero-extended to DATA_W; all other ops sign-extend imm[15].
- Load-use hazard (combinational): load_use_stall=1 when in_valid=1, mem_read=1, out_valid=1, rt_addr≠0, and either (incoming rs field == rt_addr) or (incoming rt field == rt_addr and incoming op ∈ {0x00, 0x04, 0x05, 0x2b}). Masked to 0 while stall=1 or flush=1.
- Per-edge update priority: reset > flush > stall > load_use_stall > normal.
  - flush: out_valid=0, mem_read=0; other outputs 0.
  - stall: all field outputs hold; rs/rt re-read (with bypass) from internally held rs/rt addresses, so writebacks during the stall are visible; out_valid/mem_read hold.
  - load_use_stall: bubble; out_valid=0, mem_read=0, fields 0.
  - normal: capture all fields/operands from instruction; out_valid=in_valid; mem_read=in_valid & (op==0x23).
- Writeback to the register file happens in all cases except reset.

## Timing
- Reset (async assert, any time): all outputs 0, all registers 0, held addresses 0; load_use_stall=0. First capture on the first posedge after deassertion.
- Latency: instruction at cycle N edge → outputs valid after edge N (1 cycle).
- Writeback in cycle N is visible to a decode captured at the same edge N (bypass), not only at N+1.
- Load-use: lw at ID/EX plus dependent instruction in IF/ID → exactly one bubble; dependent instruction is captured one cycle later, when mem_read is 0.
- Simultaneous flush and load_use_stall: flush wins, stall output 0.
- Reset mid-stall: stall state discarded; outputs 0.

## Test plan
- Reset: write r5=0xDEADBEEF, assert reset asynchronously between edges → all outputs 0 immediately; a subsequent read of r5 returns 0.
- Bypass: register_write=1, write_addr=3, write_result=0x1234 in the same cycle as decode of `add r1,r3,r0` → rs=0x1234 one cycle later; a write to r0 → rs reads 0.
- Immediates: ori imm 0x8001 → 0x00008001; addi imm 0x8001 → 0xFFFF8001; lui 0x8001 → 0x80010000; DATA_W=64 sign case → 0xFFFFFFFFFFFF8001.
- Load-use: `lw r2,0(r1)` then `add r4,r2,r5` → load_use_stall=1 for one cycle, one out_valid=0 bubble, add captured next; `lw r0` or independent add → no stall.
- Stall refresh: capture rs=r7 (=1), hold stall for 2 cycles while WB writes r7=9 → fields hold, rs becomes 9; release → next instruction captured.
- Flush priority: flush together with stall and a hazard → out_valid=0, mem_read=0, load_use_stall=0; REG_COUNT=16 write to r20 ignored, read of r20 returns 0.
